// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_four_bit_sub.sv
// Combinational 4-bit subtractor with borrow lookahead: diff = x - y - bin.
module four_bit_sub
  import sub_pkg::*;
(
  input  nibble_t x,
  input  nibble_t y,
  input  logic    bin,
  output nibble_t diff,
  output logic    bout
);

  nibble_t g;
  nibble_t p;
  logic [NIB_W:0] bc;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  // Borrow into each bit computed directly from generate/propagate terms.
  assign bc[0] = bin;
  assign bc[1] = g[0] | (p[0] & bin);
  assign bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);
  assign bc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

  assign diff = x ^ y ^ bc[NIB_W-1:0];
  assign bout = bc[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor d = a - b, one nibble per clock LSB first,
// with valid/ready handshakes on operands and result.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("WIDTH must be a positive multiple of 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q, d_next;
  logic [IDX_W-1:0] idx_q;
  logic             brw_q;
  logic             borrow_q, ovf_q, zero_q;

  nibble_t          a_nib, b_nib, diff_nib;
  logic             bout_nib;
  logic             last_nib;

  assign a_nib    = a_q[int'(idx_q)*NIB_W +: NIB_W];
  assign b_nib    = b_q[int'(idx_q)*NIB_W +: NIB_W];
  assign last_nib = (idx_q == IDX_W'(NIBS - 1));

  four_bit_sub u_nib (
    .x    (a_nib),
    .y    (b_nib),
    .bin  (brw_q),
    .diff (diff_nib),
    .bout (bout_nib)
  );

  // Full result as it will stand after this edge; flags derive from it on the last nibble.
  always_comb begin
    d_next = d_q;
    d_next[int'(idx_q)*NIB_W +: NIB_W] = diff_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx_q <= '0;
            brw_q <= 1'b0;
          end
        end
        BUSY: begin
          d_q   <= d_next;
          brw_q <= bout_nib;
          idx_q <= last_nib ? '0 : idx_q + 1'b1;
          if (last_nib) begin
            borrow_q <= bout_nib;
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_next[WIDTH-1] != a_q[WIDTH-1]);
            zero_q   <= (d_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
